// File: rtl/icache_axi_rmaster_pkg.sv
// Shared types and AXI constants for the I-cache line-fill read master.
package icache_axi_rmaster_pkg;

    typedef enum logic [2:0] {IDLE, AR, RD, DLV, REL} fill_state_t;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_WORD  = 3'b010;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam int         LINE_WORDS = 4;

    // One extra bit lets the beat counter sit at LINE_WORDS and flag overrun beats.
    function automatic int beat_w(input int words);
        return $clog2(words) + 1;
    endfunction

endpackage

// File: rtl/icache_axi_rmaster_fill_line_buf.sv
// Line buffer for one cache line: one write port, one asynchronous read port, bulk clear.
module icache_axi_rmaster_fill_line_buf #(
    parameter int DATA_W = 32,
    parameter int WORDS  = 4,
    localparam int IDX_W = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              we,
    input  logic [IDX_W-1:0]  widx,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  ridx,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [WORDS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= '0;
        end else if (we) begin
            mem[widx] <= wdata;
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/icache_axi_rmaster.sv
// I-cache miss-fill engine: one INCR AXI read burst per line, then a 4-cycle word delivery.
module icache_axi_rmaster #(
    parameter logic [3:0] AXI_ID     = 4'h0,
    parameter int         LINE_WORDS = icache_axi_rmaster_pkg::LINE_WORDS,
    parameter int         ADDR_W     = 32,
    parameter int         DATA_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              I_rreq,
    input  logic [ADDR_W-1:0] I_addr,
    output logic [DATA_W-1:0] I_out,
    output logic              I_wait,
    output logic [3:0]        ARID,
    output logic [ADDR_W-1:0] ARADDR,
    output logic [3:0]        ARLEN,
    output logic [2:0]        ARSIZE,
    output logic [1:0]        ARBURST,
    output logic              ARVALID,
    input  logic              ARREADY,
    input  logic [3:0]        RID,
    input  logic [DATA_W-1:0] RDATA,
    input  logic [1:0]        RRESP,
    input  logic              RLAST,
    input  logic              RVALID,
    output logic              RREADY,
    output logic              fill_err,
    output logic [31:0]       fill_cnt
);
    import icache_axi_rmaster_pkg::*;

    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam int CNT_W = beat_w(LINE_WORDS);
    localparam logic [CNT_W-1:0] FULL_BEAT = CNT_W'(LINE_WORDS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LINE_WORDS - 1);

    fill_state_t       state_q, state_d;
    logic [ADDR_W-1:0] araddr_q;
    logic [CNT_W-1:0]  beat_q;
    logic [IDX_W-1:0]  dlv_idx_q;
    logic              drop_q;
    logic [DATA_W-1:0] out_q;
    logic              wait_q;
    logic              err_q;
    logic [31:0]       cnt_q;

    logic              line_clr, r_beat, r_last, in_line, buf_we;
    logic [IDX_W-1:0]  buf_ridx;
    logic [DATA_W-1:0] buf_rdata;
    logic              unused_ok;

    assign line_clr = (state_q == IDLE) && I_rreq;
    assign r_beat   = (state_q == RD) && RVALID;
    assign r_last   = r_beat && RLAST;
    assign in_line  = beat_q < FULL_BEAT;
    assign buf_we   = r_beat && in_line;
    assign buf_ridx = (state_q == DLV) ? dlv_idx_q + 1'b1 : '0;
    assign unused_ok = ^{RID, I_addr[3:0]};

    icache_axi_rmaster_fill_line_buf #(
        .DATA_W (DATA_W),
        .WORDS  (LINE_WORDS)
    ) u_line_buf (
        .clk   (clk),
        .rst   (rst),
        .clr   (line_clr),
        .we    (buf_we),
        .widx  (beat_q[IDX_W-1:0]),
        .wdata (RDATA),
        .ridx  (buf_ridx),
        .rdata (buf_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // A withdrawn request still drains the burst; it only skips delivery.
    always_comb begin
        state_d = state_q;
        ARVALID = 1'b0;
        RREADY  = 1'b0;
        case (state_q)
            IDLE: if (I_rreq) state_d = AR;
            AR: begin
                ARVALID = 1'b1;
                if (ARREADY) state_d = RD;
            end
            RD: begin
                RREADY = 1'b1;
                if (r_last) state_d = (drop_q || !I_rreq) ? REL : DLV;
            end
            DLV: if (dlv_idx_q == LAST_IDX) state_d = REL;
            REL: if (!I_rreq) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---- datapath registers: address latch, beat tracking, registered delivery ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            araddr_q  <= '0;
            beat_q    <= '0;
            dlv_idx_q <= '0;
            drop_q    <= 1'b0;
            out_q     <= '0;
            wait_q    <= 1'b1;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            if (line_clr) begin
                araddr_q <= {I_addr[ADDR_W-1:4], 4'h0};
                beat_q   <= '0;
                drop_q   <= 1'b0;
            end
            if ((state_q == AR || state_q == RD) && !I_rreq) drop_q <= 1'b1;
            if (buf_we) beat_q <= beat_q + 1'b1;
            if (r_beat && (RRESP != RESP_OKAY || !in_line || (RLAST && beat_q < LAST_BEAT)))
                err_q <= 1'b1;
            dlv_idx_q <= (state_q == DLV) ? dlv_idx_q + 1'b1 : '0;
            wait_q    <= (state_d != DLV);
            // Word 0 may be landing in the buffer on this same edge when RLAST comes on beat 0.
            if (state_d == DLV)
                out_q <= (state_q == RD && beat_q == '0) ? RDATA : buf_rdata;
            if (state_q == DLV && state_d == REL) cnt_q <= cnt_q + 32'd1;
        end
    end

    assign ARADDR   = araddr_q;
    assign ARID     = AXI_ID;
    assign ARLEN    = 4'(LINE_WORDS - 1);
    assign ARSIZE   = SIZE_WORD;
    assign ARBURST  = BURST_INCR;
    assign I_out    = out_q;
    assign I_wait   = wait_q;
    assign fill_err = err_q;
    assign fill_cnt = cnt_q;

endmodule

// File: tb/tb_icache_axi_rmaster.sv
// Directed and randomized fills against a line-level reference model of the fill engine.
module tb_icache_axi_rmaster;

    logic        clk = 1'b0;
    logic        rst;
    logic        I_rreq;
    logic [31:0] I_addr;
    logic [31:0] I_out;
    logic        I_wait;
    logic [3:0]  ARID;
    logic [31:0] ARADDR;
    logic [3:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID;
    logic        ARREADY;
    logic [3:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;
    logic        fill_err;
    logic [31:0] fill_cnt;

    always #5 clk = ~clk;

    icache_axi_rmaster dut (
        .clk(clk), .rst(rst), .I_rreq(I_rreq), .I_addr(I_addr), .I_out(I_out), .I_wait(I_wait),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .RID(RID), .RDATA(RDATA), .RRESP(RRESP),
        .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY), .fill_err(fill_err), .fill_cnt(fill_cnt)
    );

    int          checks   = 0;
    int          failures = 0;
    int          exp_cnt  = 0;
    logic        exp_err  = 1'b0;
    logic [31:0] bdata [8];
    logic [1:0]  bresp [8];
    logic [31:0] m_words [4];
    logic        m_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Line contents and error outcome of a burst of n beats, straight from the fill rules.
    task automatic model(input int n);
        m_err = (n < 4);
        for (int i = 0; i < 4; i++) m_words[i] = 32'h0;
        for (int i = 0; i < n; i++) begin
            if (i < 4) m_words[i] = bdata[i];
            else       m_err = 1'b1;
            if (bresp[i] != 2'b00) m_err = 1'b1;
        end
    endtask

    task automatic seq_beats(input logic [31:0] base);
        for (int i = 0; i < 8; i++) begin
            bdata[i] = base + 32'(i);
            bresp[i] = 2'b00;
        end
    endtask

    task automatic do_fill(input string name, input logic [31:0] addr, input int ar_delay,
                           input int gap, input int nbeats, input int drop_at, input int exp_first);
        logic [31:0] got[$];
        int          gcyc[$];
        int          bi, ar_wait, gap_cnt, post, exp_n;
        bit          ar_done, ar_seen, prev_arv, prev_rrdy, ar_bad, done;
        logic [31:0] exp_addr;
        bi = 0; ar_wait = 0; gap_cnt = 0; post = 0;
        ar_done = 0; ar_seen = 0; prev_arv = 0; prev_rrdy = 0; ar_bad = 0; done = 0;
        exp_addr = {addr[31:4], 4'h0};
        model(nbeats);
        I_addr = addr;
        I_rreq = 1'b1;
        for (int j = 1; j <= 400 && !done; j++) begin
            @(negedge clk);
            if (prev_arv && ARREADY) ar_done = 1;
            if (prev_rrdy && RVALID) begin
                bi++;
                RVALID = 1'b0;
                RLAST  = 1'b0;
                gap_cnt = gap;
            end
            prev_arv  = ARVALID;
            prev_rrdy = RREADY;
            if (ARVALID) ar_seen = 1;
            if (ARVALID && (ARADDR !== exp_addr || ARLEN !== 4'd3 || ARSIZE !== 3'b010 ||
                            ARBURST !== 2'b01 || ARID !== 4'h0)) ar_bad = 1;
            if (ar_done && ARVALID) ar_bad = 1;
            if (ar_seen && !ar_done && !ARVALID) ar_bad = 1;
            if (I_wait === 1'b0) begin
                got.push_back(I_out);
                gcyc.push_back(j);
            end
            if (j == drop_at) I_rreq = 1'b0;
            if (ARVALID && !ar_done) begin
                ARREADY = (ar_wait >= ar_delay);
                ar_wait++;
            end else begin
                ARREADY = 1'b0;
            end
            if (ar_done && bi < nbeats && !RVALID) begin
                if (gap_cnt > 0) gap_cnt--;
                else begin
                    RVALID = 1'b1;
                    RDATA  = bdata[bi];
                    RRESP  = bresp[bi];
                    RLAST  = (bi == nbeats - 1);
                    RID    = 4'($urandom);
                end
            end
            if (bi == nbeats) begin
                post++;
                if (post >= 8) done = 1;
            end
        end
        I_rreq  = 1'b0;
        ARREADY = 1'b0;
        repeat (2) @(negedge clk);
        exp_n = (drop_at < 0) ? 4 : 0;
        if (drop_at < 0) exp_cnt++;
        exp_err = exp_err | m_err;
        chk({name, "_completed"}, done, 1);
        chk({name, "_ar_fields"}, ar_bad, 0);
        chk({name, "_word_count"}, got.size(), exp_n);
        for (int i = 0; i < exp_n && i < got.size(); i++)
            chk($sformatf("%s_word%0d", name, i), got[i], m_words[i]);
        if (got.size() == 4) chk({name, "_consecutive"}, gcyc[3] - gcyc[0], 3);
        if (exp_first >= 0 && got.size() > 0) chk({name, "_first_cycle"}, gcyc[0], exp_first);
        chk({name, "_fill_cnt"}, fill_cnt, exp_cnt);
        chk({name, "_fill_err"}, fill_err, exp_err);
        chk({name, "_idle_wait"}, I_wait, 1);
    endtask

    initial begin
        rst = 1'b0; I_rreq = 1'b0; I_addr = '0; ARREADY = 1'b0; RID = '0;
        RDATA = '0; RRESP = '0; RLAST = 1'b0; RVALID = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_arvalid", ARVALID, 0);
        chk("rst_rready", RREADY, 0);
        chk("rst_wait", I_wait, 1);
        chk("rst_out", I_out, 0);
        chk("rst_err", fill_err, 0);
        chk("rst_cnt", fill_cnt, 0);
        rst = 1'b1;
        @(negedge clk);

        seq_beats(32'hA0);
        do_fill("zero_wait", 32'h0000_1234, 0, 0, 4, -1, 6);

        seq_beats(32'hB0);
        do_fill("backpressure", 32'h0000_5678, 3, 2, 4, -1, -1);

        seq_beats(32'hC0);
        bresp[2] = 2'b10;
        do_fill("err_resp", 32'h0000_9ABC, 0, 0, 4, -1, -1);

        seq_beats(32'hD0);
        do_fill("good_after_err", 32'h0001_0000, 1, 1, 4, -1, -1);

        seq_beats(32'hE0);
        do_fill("early_rlast", 32'h0002_0010, 0, 0, 2, -1, -1);

        seq_beats(32'hF0);
        do_fill("overrun", 32'h0003_0020, 0, 1, 6, -1, -1);

        seq_beats(32'h10);
        do_fill("drop_rd", 32'h0004_0030, 0, 2, 4, 3, -1);

        seq_beats(32'h20);
        do_fill("after_drop", 32'h0005_0040, 0, 0, 4, -1, 6);

        // Reset pulled while the burst is in its data phase.
        I_addr = 32'h0006_0050; I_rreq = 1'b1; ARREADY = 1'b1;
        @(negedge clk);
        @(negedge clk);
        ARREADY = 1'b0; RVALID = 1'b1; RDATA = 32'h55; RRESP = 2'b00; RLAST = 1'b0;
        @(negedge clk);
        chk("mid_rst_pre_rready", RREADY, 1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_arvalid", ARVALID, 0);
        chk("mid_rst_rready", RREADY, 0);
        chk("mid_rst_wait", I_wait, 1);
        chk("mid_rst_cnt", fill_cnt, 0);
        chk("mid_rst_err", fill_err, 0);
        RVALID = 1'b0; I_rreq = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        exp_cnt = 0;
        exp_err = 1'b0;

        seq_beats(32'h30);
        do_fill("post_rst", 32'h0007_0068, 0, 0, 4, -1, 6);

        for (int r = 0; r < 12; r++) begin
            int nb, dr;
            for (int i = 0; i < 8; i++) begin
                bdata[i] = $urandom;
                bresp[i] = ($urandom_range(0, 9) == 0) ? 2'b10 : 2'b00;
            end
            nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 4;
            dr = ($urandom_range(0, 4) == 0) ? 2 : -1;
            do_fill($sformatf("rand%0d", r), $urandom, int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 3)), nb, dr, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
